// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two requester channels and the shared memory port.
// The arbiter connects through the slave modport; requesters and the
// memory model drive or observe the signals through the master modport.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // requester 0 (mips core)
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              gnt0;
  logic [DATA_W-1:0] rdata0;
  logic              rvalid0;

  // requester 1 (loader / debug master)
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              gnt1;
  logic [DATA_W-1:0] rdata1;
  logic              rvalid1;

  // shared memory port
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wr_ena;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_rd_data;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    output gnt0, rdata0, rvalid0,
    output gnt1, rdata1, rvalid1,
    output mem_addr, mem_wr_ena, mem_wr_data,
    input  mem_rd_data
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    input  gnt0, rdata0, rvalid0,
    input  gnt1, rdata1, rvalid1,
    input  mem_addr, mem_wr_ena, mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-cycle memory port between the mips
// core (requester 0) and a loader/debug master (requester 1).
// Round-robin ownership with a bounded burst: an owner keeps the port for
// at most MAX_BURST consecutive grants while the other side is waiting.
// Grants and the memory mux are decoded from the registered owner state,
// so a request raised in IDLE is served on the following cycle.
// Read data is captured at the end of the grant cycle and flagged with a
// one-cycle rvalid pulse.
// Optional build macro MEM_ARB_PERF_EN adds 32-bit wrapping counters:
//   perf_gnt0 / perf_gnt1 : granted cycles per requester
//   perf_wait1            : cycles with req1 high and gnt1 low
module mem_port_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef MEM_ARB_PERF_EN
  output logic [31:0] perf_gnt0,
  output logic [31:0] perf_gnt1,
  output logic [31:0] perf_wait1,
`endif
  mem_port_arbiter_if.slave bus
);

  // bcnt counts grants already given in the current tenure, saturating
  // at MAX_BURST-1; reaching that value with the other side waiting
  // hands the port over.
  localparam int                BCNT_W    = $clog2(MAX_BURST) + 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [BCNT_W-1:0] bcnt_q,  bcnt_d;
  logic              ptr_q,   ptr_d;   // 0: requester 0 wins a tie in IDLE

  logic              gnt0, gnt1;

  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q,  rdata0_d;
  logic [DATA_W-1:0] rdata1_q,  rdata1_d;

  // State register: owner, burst count, tie pointer and read-return flops
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bcnt_q    <= '0;
      ptr_q     <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      ptr_q     <= ptr_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  // Next owner: round-robin with burst limit and early hand-over on a dropped request
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        bcnt_d = '0;
        if (bus.req0 && bus.req1) begin
          state_d = ptr_q ? OWN1 : OWN0;
        end else if (bus.req0) begin
          state_d = OWN0;
        end else if (bus.req1) begin
          state_d = OWN1;
        end
      end
      OWN0: begin
        if (!bus.req0) begin
          // Owner let go: the idle cycle just spent was not an access.
          state_d = bus.req1 ? OWN1 : IDLE;
          bcnt_d  = '0;
          ptr_d   = 1'b1;
        end else if (bus.req1 && (bcnt_q == BCNT_LAST)) begin
          state_d = OWN1;
          bcnt_d  = '0;
          ptr_d   = 1'b0;
        end else if (bcnt_q < BCNT_LAST) begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
      end
      OWN1: begin
        if (!bus.req1) begin
          state_d = bus.req0 ? OWN0 : IDLE;
          bcnt_d  = '0;
          ptr_d   = 1'b0;
        end else if (bus.req0 && (bcnt_q == BCNT_LAST)) begin
          state_d = OWN0;
          bcnt_d  = '0;
          ptr_d   = 1'b1;
        end else if (bcnt_q < BCNT_LAST) begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        bcnt_d  = '0;
      end
    endcase
  end

  // Grants and memory mux, decoded from the registered owner only
  always_comb begin
    gnt0            = (state_q == OWN0) && bus.req0;
    gnt1            = (state_q == OWN1) && bus.req1;
    bus.mem_addr    = '0;
    bus.mem_wr_data = '0;
    bus.mem_wr_ena  = 1'b0;
    unique case (state_q)
      OWN0: begin
        bus.mem_addr    = bus.addr0;
        bus.mem_wr_data = bus.wdata0;
        bus.mem_wr_ena  = gnt0 && bus.we0;
      end
      OWN1: begin
        bus.mem_addr    = bus.addr1;
        bus.mem_wr_data = bus.wdata1;
        bus.mem_wr_ena  = gnt1 && bus.we1;
      end
      default: begin
      end
    endcase
  end

  // Read return: capture memory data on a granted read, otherwise hold
  always_comb begin
    rvalid0_d = gnt0 && !bus.we0;
    rvalid1_d = gnt1 && !bus.we1;
    rdata0_d  = rvalid0_d ? bus.mem_rd_data : rdata0_q;
    rdata1_d  = rvalid1_d ? bus.mem_rd_data : rdata1_q;
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.rvalid0 = rvalid0_q;
  assign bus.rvalid1 = rvalid1_q;
  assign bus.rdata0  = rdata0_q;
  assign bus.rdata1  = rdata1_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_gnt0_q,  perf_gnt0_d;
  logic [31:0] perf_gnt1_q,  perf_gnt1_d;
  logic [31:0] perf_wait1_q, perf_wait1_d;

  // Counter increments; all three wrap naturally at 2^32
  always_comb begin
    perf_gnt0_d  = perf_gnt0_q  + 32'(gnt0);
    perf_gnt1_d  = perf_gnt1_q  + 32'(gnt1);
    perf_wait1_d = perf_wait1_q + 32'(bus.req1 && !gnt1);
  end

  // Counter registers, cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_gnt0_q  <= '0;
      perf_gnt1_q  <= '0;
      perf_wait1_q <= '0;
    end else begin
      perf_gnt0_q  <= perf_gnt0_d;
      perf_gnt1_q  <= perf_gnt1_d;
      perf_wait1_q <= perf_wait1_d;
    end
  end

  assign perf_gnt0  = perf_gnt0_q;
  assign perf_gnt1  = perf_gnt1_q;
  assign perf_wait1 = perf_wait1_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vector table, hand-written
// multi-cycle sequences, then random traffic, all cross-checked every
// cycle against a tenure-level reference model of the arbiter.
module tb_mem_port_arbiter;
  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 4;
  localparam int NV        = 22;
  localparam int NRAND     = 2000;

  logic clk = 1'b0;
  logic rst;
  logic mem_clr;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_gnt0, perf_gnt1, perf_wait1;
`endif

  mem_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_BURST(MAX_BURST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef MEM_ARB_PERF_EN
    .perf_gnt0 (perf_gnt0),
    .perf_gnt1 (perf_gnt1),
    .perf_wait1(perf_wait1),
`endif
    .bus       (bus)
  );

  // memory model: combinational read, write at posedge
  logic [31:0] tmem [0:255];
  assign bus.mem_rd_data = tmem[bus.mem_addr[7:0]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) tmem[i] <= '0;
    end else if (bus.mem_wr_ena) begin
      tmem[bus.mem_addr[7:0]] <= bus.mem_wr_data;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_owner;   // -1 = nobody owns the port
  int          m_run;     // grants given in the current tenure
  int          m_pref;    // requester that wins a tie from idle
  logic [31:0] m_mem [0:255];
  logic        m_rv0, m_rv1;
  logic [31:0] m_rd0, m_rd1;
  logic [31:0] m_pg0, m_pg1, m_pw1;

  task automatic model_outputs(output logic eg0, output logic eg1, output logic ewr,
                               output logic [31:0] ea, output logic [31:0] ed);
    logic        rq [2];
    logic        w  [2];
    logic [31:0] a  [2];
    logic [31:0] d  [2];
    rq[0] = bus.req0;  rq[1] = bus.req1;
    w[0]  = bus.we0;   w[1]  = bus.we1;
    a[0]  = bus.addr0; a[1]  = bus.addr1;
    d[0]  = bus.wdata0; d[1] = bus.wdata1;
    eg0 = (m_owner == 0) && rq[0];
    eg1 = (m_owner == 1) && rq[1];
    if (m_owner < 0) begin
      ewr = 1'b0; ea = '0; ed = '0;
    end else begin
      ea  = a[m_owner];
      ed  = d[m_owner];
      ewr = rq[m_owner] && w[m_owner];
    end
  endtask

  task automatic model_check();
    logic eg0, eg1, ewr;
    logic [31:0] ea, ed;
    model_outputs(eg0, eg1, ewr, ea, ed);
    chk("model.gnt0",        32'(bus.gnt0),       32'(eg0));
    chk("model.gnt1",        32'(bus.gnt1),       32'(eg1));
    chk("model.mem_wr_ena",  32'(bus.mem_wr_ena), 32'(ewr));
    chk("model.mem_addr",    bus.mem_addr,        ea);
    chk("model.mem_wr_data", bus.mem_wr_data,     ed);
    chk("model.rvalid0",     32'(bus.rvalid0),    32'(m_rv0));
    chk("model.rvalid1",     32'(bus.rvalid1),    32'(m_rv1));
    chk("model.rdata0",      bus.rdata0,          m_rd0);
    chk("model.rdata1",      bus.rdata1,          m_rd1);
`ifdef MEM_ARB_PERF_EN
    chk("model.perf_gnt0",   perf_gnt0,           m_pg0);
    chk("model.perf_gnt1",   perf_gnt1,           m_pg1);
    chk("model.perf_wait1",  perf_wait1,          m_pw1);
`endif
  endtask

  task automatic model_step();
    logic eg0, eg1, ewr;
    logic [31:0] ea, ed, rdv;
    logic rq [2];
    int o, x;
    model_outputs(eg0, eg1, ewr, ea, ed);
    rq[0] = bus.req0; rq[1] = bus.req1;
    rdv = m_mem[ea[7:0]];
    if (ewr) m_mem[ea[7:0]] = ed;   // the write commits even under reset
    if (rst) begin
      m_owner = -1; m_run = 0; m_pref = 0;
      m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
      m_pg0 = '0; m_pg1 = '0; m_pw1 = '0;
    end else begin
      m_pg0 = m_pg0 + 32'(eg0);
      m_pg1 = m_pg1 + 32'(eg1);
      m_pw1 = m_pw1 + 32'(rq[1] && !eg1);
      m_rv0 = eg0 && !bus.we0;
      m_rv1 = eg1 && !bus.we1;
      if (m_rv0) m_rd0 = rdv;
      if (m_rv1) m_rd1 = rdv;
      if (m_owner < 0) begin
        if (rq[0] && rq[1]) m_owner = m_pref;
        else if (rq[0])     m_owner = 0;
        else if (rq[1])     m_owner = 1;
        m_run = 0;
      end else begin
        o = m_owner;
        x = 1 - o;
        if (!rq[o]) begin
          m_owner = rq[x] ? x : -1;
          m_run   = 0;
          m_pref  = x;
        end else begin
          m_run++;
          if (rq[x] && m_run >= MAX_BURST) begin
            m_owner = x;
            m_run   = 0;
            m_pref  = o;
          end
        end
      end
    end
  endtask

  task automatic to_negedge();
    @(negedge clk);
    model_check();
  endtask

  task automatic to_posedge();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ctl = {rst, req0, req1, we0, we1}
  task automatic drive(input logic [4:0] ctl, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] d0, input logic [31:0] d1);
    rst        = ctl[4];
    bus.req0   = ctl[3];
    bus.req1   = ctl[2];
    bus.we0    = ctl[1];
    bus.we1    = ctl[0];
    bus.addr0  = a0;
    bus.addr1  = a1;
    bus.wdata0 = d0;
    bus.wdata1 = d1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0]  ctl;   // rst req0 req1 we0 we1
    logic [31:0] a0;
    logic [31:0] a1;
    logic [31:0] d1;
    logic [4:0]  ex;    // gnt0 gnt1 mem_wr_ena rvalid0 rvalid1
    logic [31:0] xrd;   // expected read data when an rvalid is expected
  } vec_t;

  vec_t tbl [NV];

  function automatic vec_t mk(input logic [4:0] ctl, input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] d1, input logic [4:0] ex, input logic [31:0] xrd);
    vec_t v;
    v.ctl = ctl; v.a0 = a0; v.a1 = a1; v.d1 = d1; v.ex = ex; v.xrd = xrd;
    return v;
  endfunction

  // hand sequence step: exp = {gnt0, gnt1, mem_wr_ena, rvalid0}
  task automatic hcyc(input string nm, input logic [4:0] ctl, input logic [31:0] a0,
                      input logic [31:0] d0, input logic [3:0] exp);
    drive(ctl, a0, 32'h10, d0, 32'h0);
    to_negedge();
    chk({nm, ".gnt0"},       32'(bus.gnt0),       32'(exp[3]));
    chk({nm, ".gnt1"},       32'(bus.gnt1),       32'(exp[2]));
    chk({nm, ".mem_wr_ena"}, 32'(bus.mem_wr_ena), 32'(exp[1]));
    chk({nm, ".rvalid0"},    32'(bus.rvalid0),    32'(exp[0]));
    to_posedge();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, limit 500000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    m_owner = -1; m_run = 0; m_pref = 0;
    m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
    m_pg0 = '0; m_pg1 = '0; m_pw1 = '0;
    for (int i = 0; i < 256; i++) m_mem[i] = '0;

    tbl[0]  = mk(5'b11100, 32'h0,  32'h0,  32'h0,        5'b00000, 32'h0);
    tbl[1]  = mk(5'b11100, 32'h0,  32'h0,  32'h0,        5'b00000, 32'h0);
    tbl[2]  = mk(5'b11100, 32'h0,  32'h0,  32'h0,        5'b00000, 32'h0);
    tbl[3]  = mk(5'b01100, 32'h0,  32'h0,  32'h0,        5'b00000, 32'h0);
    tbl[4]  = mk(5'b01000, 32'h0,  32'h0,  32'h0,        5'b10000, 32'h0);
    tbl[5]  = mk(5'b00000, 32'h0,  32'h0,  32'h0,        5'b00010, 32'h0);
    tbl[6]  = mk(5'b00101, 32'h0,  32'h10, 32'hDEADBEEF, 5'b00000, 32'h0);
    tbl[7]  = mk(5'b00101, 32'h0,  32'h10, 32'hDEADBEEF, 5'b01100, 32'h0);
    tbl[8]  = mk(5'b00100, 32'h0,  32'h10, 32'h0,        5'b01000, 32'h0);
    tbl[9]  = mk(5'b00000, 32'h0,  32'h10, 32'h0,        5'b00001, 32'hDEADBEEF);
    tbl[10] = mk(5'b00000, 32'h0,  32'h0,  32'h0,        5'b00000, 32'h0);
    tbl[11] = mk(5'b01100, 32'h10, 32'h10, 32'h0,        5'b00000, 32'h0);
    tbl[12] = mk(5'b01100, 32'h10, 32'h10, 32'h0,        5'b10000, 32'h0);
    tbl[13] = mk(5'b01100, 32'h10, 32'h10, 32'h0,        5'b10010, 32'hDEADBEEF);
    tbl[14] = mk(5'b01100, 32'h10, 32'h10, 32'h0,        5'b10010, 32'hDEADBEEF);
    tbl[15] = mk(5'b01100, 32'h10, 32'h10, 32'h0,        5'b10010, 32'hDEADBEEF);
    tbl[16] = mk(5'b01100, 32'h10, 32'h10, 32'h0,        5'b01010, 32'hDEADBEEF);
    tbl[17] = mk(5'b01100, 32'h10, 32'h10, 32'h0,        5'b01001, 32'hDEADBEEF);
    tbl[18] = mk(5'b01100, 32'h10, 32'h10, 32'h0,        5'b01001, 32'hDEADBEEF);
    tbl[19] = mk(5'b01100, 32'h10, 32'h10, 32'h0,        5'b01001, 32'hDEADBEEF);
    tbl[20] = mk(5'b01100, 32'h10, 32'h10, 32'h0,        5'b10001, 32'hDEADBEEF);
    tbl[21] = mk(5'b00000, 32'h10, 32'h10, 32'h0,        5'b00010, 32'hDEADBEEF);

    // power-up: one reset cycle that also clears the memory model
    mem_clr = 1'b1;
    drive(5'b11100, 32'h0, 32'h0, 32'h0, 32'h0);
    to_posedge();
    mem_clr = 1'b0;

    // directed table: reset, write/read on requester 1, burst alternation
    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].ctl, tbl[i].a0, tbl[i].a1, 32'h0, tbl[i].d1);
      to_negedge();
      chk($sformatf("vec%0d.gnt0", i),       32'(bus.gnt0),       32'(tbl[i].ex[4]));
      chk($sformatf("vec%0d.gnt1", i),       32'(bus.gnt1),       32'(tbl[i].ex[3]));
      chk($sformatf("vec%0d.mem_wr_ena", i), 32'(bus.mem_wr_ena), 32'(tbl[i].ex[2]));
      chk($sformatf("vec%0d.rvalid0", i),    32'(bus.rvalid0),    32'(tbl[i].ex[1]));
      chk($sformatf("vec%0d.rvalid1", i),    32'(bus.rvalid1),    32'(tbl[i].ex[0]));
      if (tbl[i].ex[1]) chk($sformatf("vec%0d.rdata0", i), bus.rdata0, tbl[i].xrd);
      if (tbl[i].ex[0]) chk($sformatf("vec%0d.rdata1", i), bus.rdata1, tbl[i].xrd);
      if (tbl[i].ctl[4]) chk($sformatf("vec%0d.mem_addr", i), bus.mem_addr, 32'h0);
      to_posedge();
    end

    // early release: req0 owns, drops after two grants while req1 waits
    hcyc("rel0", 5'b01000, 32'h10, 32'h0, 4'b0000);
    hcyc("rel1", 5'b01100, 32'h10, 32'h0, 4'b1000);
    hcyc("rel2", 5'b01100, 32'h10, 32'h0, 4'b1001);
    hcyc("rel3", 5'b00100, 32'h10, 32'h0, 4'b0001);
    hcyc("rel4", 5'b00100, 32'h10, 32'h0, 4'b0100);
    hcyc("rel5", 5'b00000, 32'h10, 32'h0, 4'b0000);
    hcyc("rel6", 5'b01100, 32'h10, 32'h0, 4'b0000);
    hcyc("rel7", 5'b01100, 32'h10, 32'h0, 4'b1000);
    hcyc("rel8", 5'b00000, 32'h10, 32'h0, 4'b0001);

    // reset during a granted write, then during a granted read
    hcyc("rstw0", 5'b01010, 32'h20, 32'hCAFEF00D, 4'b0000);
    hcyc("rstw1", 5'b11010, 32'h20, 32'hCAFEF00D, 4'b1010);
    hcyc("rstw2", 5'b00000, 32'h20, 32'h0,        4'b0000);
    chk("rstw.mem20", tmem[8'h20], 32'hCAFEF00D);
    hcyc("rstw3", 5'b01100, 32'h20, 32'h0,        4'b0000);
    hcyc("rstw4", 5'b01100, 32'h20, 32'h0,        4'b1000);
    hcyc("rstr5", 5'b11100, 32'h20, 32'h0,        4'b1001);
    hcyc("rstr6", 5'b00000, 32'h20, 32'h0,        4'b0000);

    // random traffic against the reference model
    for (int c = 0; c < NRAND; c++) begin
      rst        = ($urandom_range(0, 63) == 0);
      bus.req0   = ($urandom_range(0, 3) != 0);
      bus.req1   = ($urandom_range(0, 3) != 0);
      bus.we0    = ($urandom_range(0, 2) == 0);
      bus.we1    = ($urandom_range(0, 2) == 0);
      bus.addr0  = $urandom;
      bus.addr1  = $urandom;
      bus.wdata0 = $urandom;
      bus.wdata1 = $urandom;
      to_negedge();
      to_posedge();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
